// File: rtl/alu_pkg.sv
// Shared opcode encodings and default sizing for the EX-stage ALU and multiply/divide unit.
package alu_pkg;

  localparam int DEFAULT_WIDTH      = 32;
  localparam int DEFAULT_MUL_CYCLES = 5;
  localparam int DEFAULT_DIV_CYCLES = 10;

  // ALU operation select; codes 12-15 yield zero.
  localparam logic [3:0] ALUOP_ADD  = 4'd0;
  localparam logic [3:0] ALUOP_SUB  = 4'd1;
  localparam logic [3:0] ALUOP_AND  = 4'd2;
  localparam logic [3:0] ALUOP_OR   = 4'd3;
  localparam logic [3:0] ALUOP_XOR  = 4'd4;
  localparam logic [3:0] ALUOP_LUI  = 4'd5;
  localparam logic [3:0] ALUOP_NOR  = 4'd6;
  localparam logic [3:0] ALUOP_SLT  = 4'd7;
  localparam logic [3:0] ALUOP_SLTU = 4'd8;
  localparam logic [3:0] ALUOP_SLL  = 4'd9;
  localparam logic [3:0] ALUOP_SRL  = 4'd10;
  localparam logic [3:0] ALUOP_SRA  = 4'd11;

  // MDU operation select; 7-10 are only meaningful with the accumulate feature.
  localparam logic [3:0] MDOP_NOP   = 4'd0;
  localparam logic [3:0] MDOP_MULT  = 4'd1;
  localparam logic [3:0] MDOP_MULTU = 4'd2;
  localparam logic [3:0] MDOP_DIV   = 4'd3;
  localparam logic [3:0] MDOP_DIVU  = 4'd4;
  localparam logic [3:0] MDOP_MTHI  = 4'd5;
  localparam logic [3:0] MDOP_MTLO  = 4'd6;
  localparam logic [3:0] MDOP_MADD  = 4'd7;
  localparam logic [3:0] MDOP_MADDU = 4'd8;
  localparam logic [3:0] MDOP_MSUB  = 4'd9;
  localparam logic [3:0] MDOP_MSUBU = 4'd10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Multi-cycle multiply/divide unit: latency counter, result staging, HI/LO and flush handling.
// Optional macro MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu_core
  import alu_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int MUL_CYCLES = DEFAULT_MUL_CYCLES,
  parameter int DIV_CYCLES = DEFAULT_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       md_op,
  input  logic             md_start,
  input  logic             md_cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = max_int(MUL_CYCLES, DIV_CYCLES);
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   stage_hi, stage_lo;
  logic               stage_we;

  logic               launch_ok;
  logic               mul_signed, div_signed;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b, divisor, uquo, urem, quo, rem;
`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] acc_add, acc_sub;
`endif

  assign busy      = (cnt != '0);
  assign hi        = hi_q;
  assign lo        = lo_q;
  // A flush on the same edge as a start suppresses the launch, MTHI/MTLO included.
  assign launch_ok = md_start & ~busy & ~md_cancel;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    mul_signed = 1'b0;
    div_signed = 1'b0;
    case (md_op)
      MDOP_MULT, MDOP_MADD, MDOP_MSUB: mul_signed = 1'b1;
      MDOP_DIV:                        div_signed = 1'b1;
      default: ;
    endcase

    // Sign/zero extend to 2*WIDTH so one multiplier yields the full product mod 2^(2*WIDTH).
    ext_a = mul_signed ? {{WIDTH{src1[WIDTH-1]}}, src1} : {{WIDTH{1'b0}}, src1};
    ext_b = mul_signed ? {{WIDTH{src2[WIDTH-1]}}, src2} : {{WIDTH{1'b0}}, src2};
    prod  = ext_a * ext_b;

    // Magnitude division keeps most-negative / -1 well defined (quotient wraps, remainder 0).
    a_neg   = div_signed & src1[WIDTH-1];
    b_neg   = div_signed & src2[WIDTH-1];
    mag_a   = a_neg ? -src1 : src1;
    mag_b   = b_neg ? -src2 : src2;
    divisor = (src2 == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
    uquo    = mag_a / divisor;
    urem    = mag_a % divisor;
    quo     = (a_neg ^ b_neg) ? -uquo : uquo;
    rem     = a_neg ? -urem : urem;
  end

`ifdef MDU_MADD_EN
  assign acc_add = {hi_q, lo_q} + prod;
  assign acc_sub = {hi_q, lo_q} - prod;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      stage_hi <= '0;
      stage_lo <= '0;
      stage_we <= 1'b0;
    end else if (busy) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (md_cancel) begin
        cnt <= '0;
      end else begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1) && stage_we) begin
          hi_q <= stage_hi;
          lo_q <= stage_lo;
        end
      end
    end else if (launch_ok) begin
      case (md_op)
        MDOP_MULT, MDOP_MULTU: begin
          {stage_hi, stage_lo} <= prod;
          stage_we             <= 1'b1;
          cnt                  <= CW'(MUL_CYCLES);
        end
        MDOP_DIV, MDOP_DIVU: begin
          stage_hi <= rem;
          stage_lo <= quo;
          stage_we <= (src2 != '0);
          cnt      <= CW'(DIV_CYCLES);
        end
        MDOP_MTHI: hi_q <= src1;
        MDOP_MTLO: lo_q <= src1;
`ifdef MDU_MADD_EN
        MDOP_MADD, MDOP_MADDU: begin
          {stage_hi, stage_lo} <= acc_add;
          stage_we             <= 1'b1;
          cnt                  <= CW'(MUL_CYCLES);
        end
        MDOP_MSUB, MDOP_MSUBU: begin
          {stage_hi, stage_lo} <= acc_sub;
          stage_we             <= 1'b1;
          cnt                  <= CW'(MUL_CYCLES);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage execution unit: combinational ALU plus the sequential multiply/divide unit.
// Optional macro MDU_MADD_EN enables the accumulate ops inside mdu_core.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int MUL_CYCLES = DEFAULT_MUL_CYCLES,
  parameter int DIV_CYCLES = DEFAULT_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       aluop,
  output logic [WIDTH-1:0] result,
  input  logic [3:0]       md_op,
  input  logic             md_start,
  input  logic             md_cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SH = $clog2(WIDTH);

  logic [SH-1:0] sh;
  assign sh = src1[SH-1:0];

  always_comb begin
    result = '0;
    case (aluop)
      ALUOP_ADD:  result = src1 + src2;
      ALUOP_SUB:  result = src1 - src2;
      ALUOP_AND:  result = src1 & src2;
      ALUOP_OR:   result = src1 | src2;
      ALUOP_XOR:  result = src1 ^ src2;
      ALUOP_LUI:  result = src2 << (WIDTH / 2);
      ALUOP_NOR:  result = ~(src1 | src2);
      ALUOP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
      ALUOP_SLTU: result = {{(WIDTH-1){1'b0}}, (src1 < src2)};
      ALUOP_SLL:  result = src2 << sh;
      ALUOP_SRL:  result = src2 >> sh;
      ALUOP_SRA:  result = $unsigned($signed(src2) >>> sh);
      default:    result = '0;
    endcase
  end

  mdu_core #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .src1      (src1),
    .src2      (src2),
    .md_op     (md_op),
    .md_start  (md_start),
    .md_cancel (md_cancel),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo)
  );

endmodule
